// File: rtl/det.sv
// Serial bit-pattern detector: shifts xin into an N-bit history and raises a
// registered one-cycle flag when the newest N bits equal PATTERN.
module det #(
   parameter int           N       = 4,
   parameter logic [N-1:0] PATTERN = 4'b1011,
   parameter bit           OVERLAP = 1'b1
) (
   input  logic clk,
   input  logic rstn,
   input  logic xin,
   output logic det_o
);

   localparam int CW = $clog2(N + 1);

   logic [N-1:0]  hist;
   logic [N-1:0]  next_hist;
   logic [CW-1:0] fill;
   logic          full;
   logic          match;

   generate
      if (N == 1) begin : g_one
         assign next_hist = xin;
      end else begin : g_many
         assign next_hist = {hist[N-2:0], xin};
      end
   endgenerate

   // Window only counts once N bits have arrived, so a cleared history can
   // never fake a match against an all-zeros pattern.
   assign full  = (32'(fill) + 32'd1) >= 32'(N);
   assign match = (next_hist == PATTERN) && full;

   // rstn is active-high despite its name.
   always_ff @(posedge clk or posedge rstn) begin
      if (rstn) begin
         hist  <= '0;
         fill  <= '0;
         det_o <= 1'b0;
      end else begin
         det_o <= match;
         if (match && !OVERLAP) begin
            hist <= '0;
            fill <= '0;
         end else begin
            hist <= next_hist;
            if (fill != CW'(N))
               fill <= fill + 1'b1;
         end
      end
   end

endmodule

// File: tb/tb_det.sv
// Directed table-driven bench for det across several parameter sets.
module tb_det;

   logic clk = 1'b0;
   logic rstn;
   logic xin;
   logic det_a, det_b, det_z, det_1, det_8;

   always #5 clk = ~clk;

   // a: defaults (N=4, 1011, overlap)
   det u_a (.clk(clk), .rstn(rstn), .xin(xin), .det_o(det_a));
   // b: no overlap
   det #(.N(4), .PATTERN(4'b1011), .OVERLAP(1'b0)) u_b
      (.clk(clk), .rstn(rstn), .xin(xin), .det_o(det_b));
   // z: all-zeros pattern for fill qualification
   det #(.N(4), .PATTERN(4'b0000), .OVERLAP(1'b1)) u_z
      (.clk(clk), .rstn(rstn), .xin(xin), .det_o(det_z));
   det #(.N(1), .PATTERN(1'b1), .OVERLAP(1'b1)) u_1
      (.clk(clk), .rstn(rstn), .xin(xin), .det_o(det_1));
   det #(.N(8), .PATTERN(8'hA5), .OVERLAP(1'b1)) u_8
      (.clk(clk), .rstn(rstn), .xin(xin), .det_o(det_8));

   typedef struct {
      logic rst;
      logic x;
      int   sel;
      logic exp;
   } vec_t;

   vec_t vecs[$];
   int   n_pass = 0;
   int   n_tot  = 0;

   function automatic logic pick(input int s);
      case (s)
         0:       return det_a;
         1:       return det_b;
         2:       return det_z;
         3:       return det_1;
         default: return det_8;
      endcase
   endfunction

   task automatic add(input logic r, input logic x, input int s, input logic e);
      vec_t v;
      v.rst = r; v.x = x; v.sel = s; v.exp = e;
      vecs.push_back(v);
   endtask

   task automatic add_seq(input int s, input logic [15:0] xs, input logic [15:0] es, input int len);
      for (int i = len - 1; i >= 0; i--)
         add(1'b0, xs[i], s, es[i]);
   endtask

   task automatic step(input logic r, input logic x);
      @(negedge clk);
      rstn = r;
      xin  = x;
      @(posedge clk);
      #1;
   endtask

   task automatic check(input string name, input logic act, input logic exp);
      n_tot++;
      if (act === exp) n_pass++;
      else $display("FAIL %s: det_o=%b expected %b", name, act, exp);
   endtask

   initial begin
      rstn = 1'b1;
      xin  = 1'b0;

      // reset hold with xin toggling, then basic match 1,0,1,1,0
      add(1'b1, 1'b1, 0, 1'b0);
      add(1'b1, 1'b0, 0, 1'b0);
      add_seq(0, 16'b10110, 16'b00010, 5);
      // overlap, default instance: 1011011 -> pulses at bits 4 and 7
      add(1'b1, 1'b0, 0, 1'b0);
      add_seq(0, 16'b1011011, 16'b0001001, 7);
      // same stream, no overlap -> single pulse
      add(1'b1, 1'b0, 1, 1'b0);
      add_seq(1, 16'b1011011, 16'b0001000, 7);
      // near miss 1010111 -> pulse only at bit 6
      add(1'b1, 1'b0, 0, 1'b0);
      add_seq(0, 16'b1010111, 16'b0000010, 7);
      // all-zeros pattern: first pulse after the 4th edge, then every cycle
      add(1'b1, 1'b0, 2, 1'b0);
      add_seq(2, 16'b000000, 16'b000111, 6);
      // mid-pattern reset: 1,0,1, reset, 1 -> no pulse; then 1,0,1,1 -> one pulse
      add(1'b1, 1'b0, 0, 1'b0);
      add_seq(0, 16'b101, 16'b000, 3);
      add(1'b1, 1'b1, 0, 1'b0);
      add_seq(0, 16'b11011, 16'b00001, 5);
      // N=1: det_o follows xin one cycle later
      add(1'b1, 1'b0, 3, 1'b0);
      add_seq(3, 16'b110100, 16'b110100, 6);
      // N=8, A5 embedded twice with overlap: pulses at bits 9 and 14
      add(1'b1, 1'b0, 4, 1'b0);
      add_seq(4, 16'b01010010100101, 16'b00000000100001, 14);

      foreach (vecs[i]) begin
         step(vecs[i].rst, vecs[i].x);
         check($sformatf("vec%0d_dut%0d", i, vecs[i].sel), pick(vecs[i].sel), vecs[i].exp);
      end

      // Asynchronous reset drops det_o mid-cycle and discards the history.
      step(1'b1, 1'b0);
      step(1'b0, 1'b1);
      step(1'b0, 1'b0);
      step(1'b0, 1'b1);
      step(1'b0, 1'b1);
      check("pre_async_pulse", det_a, 1'b1);
      #2 rstn = 1'b1;
      #1 check("async_drop", det_a, 1'b0);
      step(1'b0, 1'b0);
      check("post_rst_0", det_a, 1'b0);
      step(1'b0, 1'b1);
      check("post_rst_1", det_a, 1'b0);
      step(1'b0, 1'b1);
      check("post_rst_2", det_a, 1'b0);
      step(1'b0, 1'b0);
      check("post_rst_3", det_a, 1'b0);

      $display("%0d/%0d checks passed", n_pass, n_tot);
      $finish;
   end

endmodule

// File: doc/det.md
Name: det

Overview:
- Serial bit-pattern detector. Shifts one input bit per clock into an N-bit history and flags when the most recent N bits equal PATTERN.
- Used as a generic, parameterised sequence-detect leaf in serial/control datapaths.
- Output is registered; overlapping matches are configurable.

Parameters:
- N, 4: pattern length in bits; legal range 1..32.
- PATTERN, 4'b1011: N-bit target sequence. MSB is the oldest bit (first received); LSB is the newest bit.
- OVERLAP, 1: 1 = overlapping matches allowed; 0 = history restarts after each match.

Ports:
- clk  input  1  rising-edge clock.
- rstn  input  1  asynchronous reset, active-high despite the name. Asserting it (1) resets; 0 = run.
- xin  input  1  serial data bit, sampled every rising clk edge.
- det_o  output  1  registered match flag.

Behaviour:
- Reset (rstn=1, asynchronous):
  - history <= 0, fill counter <= 0, det_o <= 0, all immediately.
  - Registers hold these values while reset is asserted.
  - Reset deassertion takes effect at the next rising edge.
- Each rising edge, not in reset:
  - next_hist = {history[N-2:0], xin}; for N=1, next_hist = xin.
  - fill counter increments, saturating at N.
  - match = (next_hist == PATTERN) AND (fill counter + 1 >= N).
  - det_o <= match.
  - history <= next_hist.
- Latency: det_o is high for exactly the one cycle after the edge that samples the final pattern bit. It is high again only on a further match.
- Consecutive matches:
  - OVERLAP=1: the bits of a match can begin the next match. Example: PATTERN 1011 with stream 1011011 gives two pulses, 3 cycles apart.
  - OVERLAP=0: on a match, history <= 0 and fill counter <= 0, so the next match needs N fresh bits. The same stream gives one pulse.
- Fill qualification: no match is reported until N bits have been sampled since reset. This holds even if PATTERN is all zeros and the history starts cleared.
- X/Z on xin is not supported; xin must be driven whenever reset is low.
- Reset asserted mid-stream: a partially received pattern is discarded and det_o drops immediately.
- Internal logic is purely synchronous, apart from the asynchronous reset.

Test Plan:
- Reset check: hold rstn=1 for 2 cycles with xin toggling -> det_o=0 throughout; after release, det_o stays 0 for the first 3 edges whatever xin is.
- Basic match, defaults (N=4, PATTERN=1011): release reset, then drive xin 1,0,1,1,0 on successive edges -> det_o=1 for exactly the cycle after the 4th edge, 0 otherwise.
- Overlap, OVERLAP=1: stream 1,0,1,1,0,1,1 -> det_o pulses after bit 4 and after bit 7.
- Overlap, OVERLAP=0: same stream -> only the first pulse.
- Near-miss: stream 1,0,1,0,1,1,1 -> pulse only after bit 6 (window 1011); none after bit 4 (window 1010).
- Fill qualification: PATTERN=4'b0000, xin=0 from reset release -> first pulse after the 4th edge, then a pulse every cycle (OVERLAP=1).
- Mid-pattern reset: send 1,0,1, assert rstn for 1 cycle, then send 1 -> no pulse; a full 1,0,1,1 afterwards -> one pulse.
- Parameter sweep: N=1, PATTERN=1 -> det_o follows xin delayed by one cycle; N=8, PATTERN=8'hA5 -> one pulse per embedded 10100101.
